// File: rtl/req_resp_arbiter.sv
// Round-robin arbiter sharing one downstream request/response channel among NUM_REQ requesters,
// with an in-order tag FIFO routing responses back. Optional strict priority for requester 0 via REQ_RESP_ARB_PRIO_EN.
module req_resp_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_SIZE       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]         req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   resp_valid,
    output logic [DATA_SIZE-1:0]                 resp_data,
    output logic                                 m_req_valid,
    output logic [DATA_SIZE-1:0]                 m_req_data,
    input  logic                                 m_req_ready,
    input  logic                                 m_resp_valid,
    input  logic [DATA_SIZE-1:0]                 m_resp_data,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err_unexp_resp
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        winner_q;
    logic                    m_req_valid_q;
    logic [DATA_SIZE-1:0]    m_req_data_q;

    logic [IDX_W-1:0]        tag_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic [NUM_REQ-1:0]      resp_valid_q;
    logic [DATA_SIZE-1:0]    resp_data_q;
    logic                    err_q;

    logic                    found_s;
    logic [IDX_W-1:0]        winner_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    grant_s;
    logic                    push_s;
    logic                    pop_s;
    logic [DATA_SIZE-1:0]    win_data_s;
    logic [NUM_REQ-1:0]      head_onehot_s;
    logic [IDX_W-1:0]        rr_next_s;

    // Pick the winning requester for this cycle from rr_ptr_q and req_valid
`ifdef REQ_RESP_ARB_PRIO_EN
    always_comb begin
        logic [IDX_W-1:0] start_s;
        logic [IDX_W-1:0] cand_s;
        found_s  = 1'b0;
        winner_s = '0;
        start_s  = '0;
        cand_s   = '0;
        if (req_valid[0]) begin
            found_s  = 1'b1;
            winner_s = '0;
        end else begin
            // Requester 0 is excluded from the rotation, so a pointer of 0 starts the search at 1
            if (rr_ptr_q == '0) begin
                start_s = IDX_W'(1);
            end else begin
                start_s = rr_ptr_q;
            end
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand_s = IDX_W'(((int'(start_s) - 1 + k) % (NUM_REQ - 1)) + 1);
                if (!found_s && req_valid[cand_s]) begin
                    found_s  = 1'b1;
                    winner_s = cand_s;
                end else begin
                    found_s  = found_s;
                end
            end
        end
    end
`else
    always_comb begin
        logic [IDX_W-1:0] cand_s;
        found_s  = 1'b0;
        winner_s = '0;
        cand_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found_s && req_valid[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end
`endif

    // Grant qualification and per-requester decode of winner data, ready pulse and response head
    always_comb begin
        full_s        = (count_q == CNT_W'(MAX_OUTSTANDING));
        empty_s       = (count_q == '0);
        grant_s       = 1'b0;
        win_data_s    = '0;
        req_ready     = '0;
        head_onehot_s = '0;
        if ((state_q == IDLE) && found_s && !full_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == IDX_W'(i)) begin
                win_data_s   = req_data[i*DATA_SIZE +: DATA_SIZE];
                req_ready[i] = grant_s;
            end else begin
                req_ready[i] = 1'b0;
            end
            if (tag_mem_q[rd_ptr_q] == IDX_W'(i)) begin
                head_onehot_s[i] = 1'b1;
            end else begin
                head_onehot_s[i] = 1'b0;
            end
        end
        push_s = grant_s;
        pop_s  = m_resp_valid && !empty_s;
        if (winner_q == IDX_W'(NUM_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = winner_q + IDX_W'(1);
        end
    end

    // Tag FIFO occupancy next-state; push and pop together cancel out
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Request-side FSM: latch winner data on grant, hold it until the downstream handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            winner_q      <= '0;
            m_req_valid_q <= 1'b0;
            m_req_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_s) begin
                        state_q       <= SEND;
                        winner_q      <= winner_s;
                        m_req_valid_q <= 1'b1;
                        m_req_data_q  <= win_data_s;
                    end else begin
                        state_q       <= IDLE;
                        m_req_valid_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (m_req_valid_q && m_req_ready) begin
                        state_q       <= IDLE;
                        m_req_valid_q <= 1'b0;
                        rr_ptr_q      <= rr_next_s;
                    end else begin
                        state_q       <= SEND;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    m_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag FIFO storage and response routing; unexpected responses set a sticky error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_s) begin
                tag_mem_q[wr_ptr_q] <= winner_s;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
                resp_valid_q <= head_onehot_s;
                resp_data_q  <= m_resp_data;
            end else begin
                resp_valid_q <= '0;
            end
            if (m_resp_valid && empty_s) begin
                err_q <= 1'b1;
            end else begin
                err_q <= err_q;
            end
        end
    end

    assign m_req_valid    = m_req_valid_q;
    assign m_req_data     = m_req_data_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign outstanding    = count_q;
    assign err_unexp_resp = err_q;

endmodule

// File: tb/tb_req_resp_arbiter.sv
// Directed self-checking bench for req_resp_arbiter (4 requesters, 16-bit data, depth-4 tag FIFO).
module tb_req_resp_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MO = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    resp_valid;
    logic [DW-1:0]    resp_data;
    logic             m_req_valid;
    logic [DW-1:0]    m_req_data;
    logic             m_req_ready;
    logic             m_resp_valid;
    logic [DW-1:0]    m_resp_data;
    logic [2:0]       outstanding;
    logic             err_unexp_resp;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    req_resp_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .m_req_valid(m_req_valid), .m_req_data(m_req_data), .m_req_ready(m_req_ready),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
        .outstanding(outstanding), .err_unexp_resp(err_unexp_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0; req_data = '0; m_req_ready = 1'b0;
        m_resp_valid = 1'b0; m_resp_data = '0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if ({m_req_valid, req_ready, resp_valid, resp_data, m_req_data, outstanding, err_unexp_resp} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got mv=%b rr=%b rv=%b rd=%h md=%h out=%0d err=%b required all zero",
                     m_req_valid, req_ready, resp_valid, resp_data, m_req_data, outstanding, err_unexp_resp);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100; req_data[2*DW +: DW] = 16'hA5A5; m_req_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL single_ready got=%b required=%b", req_ready, 4'b0100);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        tests_run++;
        if (m_req_valid !== 1'b1 || m_req_data !== 16'hA5A5 || req_ready !== 4'b0000 || outstanding !== 3'd1) begin
            tests_failed++;
            $display("FAIL single_send got mv=%b md=%h rr=%b out=%0d required mv=1 md=a5a5 rr=0000 out=1",
                     m_req_valid, m_req_data, req_ready, outstanding);
        end
        tick();
        tests_run++;
        if (m_req_valid !== 1'b0) begin
            tests_failed++; $display("FAIL single_handshake got mv=%b required=0", m_req_valid);
        end
        tick();
        m_resp_valid = 1'b1; m_resp_data = 16'h1234;
        tick();
        m_resp_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 4'b0100 || resp_data !== 16'h1234 || outstanding !== 3'd0) begin
            tests_failed++;
            $display("FAIL single_resp got rv=%b rd=%h out=%0d required rv=0100 rd=1234 out=0", resp_valid, resp_data, outstanding);
        end
        tick();
        tests_run++;
        if (resp_valid !== 4'b0000) begin
            tests_failed++; $display("FAIL single_resp_pulse got=%b required=0000", resp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_oh;
        int            exp_idx;
        do_reset();
        req_valid = 4'b1111; m_req_ready = 1'b1;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 16'hC000 + 16'(i);
        for (int g = 0; g < 5; g++) begin
`ifdef REQ_RESP_ARB_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = g % NR;
`endif
            exp_oh = 4'b0001 << exp_idx;
            #1;
            tests_run++;
            if (req_ready !== exp_oh) begin
                tests_failed++; $display("FAIL rr_grant%0d got=%b required=%b", g, req_ready, exp_oh);
            end
            tick();
            tests_run++;
            if (m_req_data !== 16'hC000 + 16'(exp_idx)) begin
                tests_failed++; $display("FAIL rr_data%0d got=%h required=%h", g, m_req_data, 16'hC000 + 16'(exp_idx));
            end
            m_resp_valid = 1'b1; m_resp_data = 16'h0100 + 16'(g);
            tick();
            m_resp_valid = 1'b0;
            tests_run++;
            if (resp_valid !== exp_oh || resp_data !== 16'h0100 + 16'(g)) begin
                tests_failed++;
                $display("FAIL rr_resp%0d got rv=%b rd=%h required rv=%b rd=%h", g, resp_valid, resp_data, exp_oh, 16'h0100 + 16'(g));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0010; req_data[1*DW +: DW] = 16'h5A3C; m_req_ready = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL bp_grant got=%b required=0010", req_ready);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (m_req_valid !== 1'b1 || m_req_data !== 16'h5A3C || req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_hold%0d got mv=%b md=%h rr=%b required mv=1 md=5a3c rr=0000", c, m_req_valid, m_req_data, req_ready);
            end
            tick();
        end
        m_req_ready = 1'b1; req_valid = 4'b0000;
        tick();
        tests_run++;
        if (m_req_valid !== 1'b0 || outstanding !== 3'd1) begin
            tests_failed++; $display("FAIL bp_release got mv=%b out=%0d required mv=0 out=1", m_req_valid, outstanding);
        end
        tick();
        tests_run++;
        if (m_req_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_single got mv=%b required=0", m_req_valid);
        end
    endtask

    task automatic test_fifo_full();
        logic [NR-1:0] exp_oh;
        do_reset();
        req_valid = 4'b1111; m_req_ready = 1'b1;
        for (int g = 0; g < MO; g++) begin
`ifdef REQ_RESP_ARB_PRIO_EN
            exp_oh = 4'b0001;
`else
            exp_oh = 4'b0001 << g;
`endif
            #1;
            tests_run++;
            if (req_ready !== exp_oh) begin
                tests_failed++; $display("FAIL full_grant%0d got=%b required=%b", g, req_ready, exp_oh);
            end
            tick(); tick();
        end
        tests_run++;
        if (outstanding !== 3'd4 || req_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL full_block got out=%0d rr=%b required out=4 rr=0000", outstanding, req_ready);
        end
        tick();
        tests_run++;
        if (m_req_valid !== 1'b0) begin
            tests_failed++; $display("FAIL full_no_send got mv=%b required=0", m_req_valid);
        end
        m_resp_valid = 1'b1; m_resp_data = 16'h7777;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL full_pop_cycle got rr=%b required=0000", req_ready);
        end
        tick();
        m_resp_valid = 1'b0;
        #1;
        tests_run++;
        if (outstanding !== 3'd3 || resp_valid !== 4'b0001 || req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL full_after_pop got out=%0d rv=%b rr=%b required out=3 rv=0001 rr=0001", outstanding, resp_valid, req_ready);
        end
        tick();
        tests_run++;
        if (outstanding !== 3'd4 || m_req_valid !== 1'b1) begin
            tests_failed++; $display("FAIL full_regrant got out=%0d mv=%b required out=4 mv=1", outstanding, m_req_valid);
        end
    endtask

    task automatic test_out_of_order_tags();
        logic [NR-1:0] seq [3];
        seq[0] = 4'b0100; seq[1] = 4'b0001; seq[2] = 4'b1000;
        do_reset();
        m_req_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            req_valid = seq[g];
            #1;
            tests_run++;
            if (req_ready !== seq[g]) begin
                tests_failed++; $display("FAIL tag_grant%0d got=%b required=%b", g, req_ready, seq[g]);
            end
            tick();
            req_valid = 4'b0000;
            tick();
        end
        for (int r = 0; r < 3; r++) begin
            m_resp_valid = 1'b1; m_resp_data = 16'(r + 1);
            tick();
            tests_run++;
            if (resp_valid !== seq[r] || resp_data !== 16'(r + 1)) begin
                tests_failed++;
                $display("FAIL tag_route%0d got rv=%b rd=%h required rv=%b rd=%h", r, resp_valid, resp_data, seq[r], 16'(r + 1));
            end
        end
        m_resp_valid = 1'b0;
        tick();
        tests_run++;
        if (resp_valid !== 4'b0000 || outstanding !== 3'd0 || err_unexp_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL tag_drain got rv=%b out=%0d err=%b required rv=0000 out=0 err=0", resp_valid, outstanding, err_unexp_resp);
        end
    endtask

    task automatic test_error_and_reset();
        do_reset();
        m_resp_valid = 1'b1; m_resp_data = 16'hBEEF;
        tick();
        m_resp_valid = 1'b0;
        tests_run++;
        if (err_unexp_resp !== 1'b1 || resp_valid !== 4'b0000) begin
            tests_failed++; $display("FAIL err_set got err=%b rv=%b required err=1 rv=0000", err_unexp_resp, resp_valid);
        end
        req_valid = 4'b0001; req_data[0 +: DW] = 16'h0F0F; m_req_ready = 1'b0;
        tick();
        req_valid = 4'b0000;
        tests_run++;
        if (m_req_valid !== 1'b1 || outstanding !== 3'd1) begin
            tests_failed++; $display("FAIL err_send got mv=%b out=%0d required mv=1 out=1", m_req_valid, outstanding);
        end
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (m_req_valid !== 1'b0 || outstanding !== 3'd0 || err_unexp_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset got mv=%b out=%0d err=%b required all 0", m_req_valid, outstanding, err_unexp_resp);
        end
        tick();
        rstn = 1'b1;
        m_resp_valid = 1'b1; m_resp_data = 16'h4444;
        tick();
        m_resp_valid = 1'b0;
        tests_run++;
        if (err_unexp_resp !== 1'b1 || resp_valid !== 4'b0000) begin
            tests_failed++; $display("FAIL err_after_reset got err=%b rv=%b required err=1 rv=0000", err_unexp_resp, resp_valid);
        end
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = '0; req_data = '0; m_req_ready = 1'b0;
        m_resp_valid = 1'b0; m_resp_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fifo_full();
        test_out_of_order_tags();
        test_error_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
